// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_pkg;

    localparam int LED_RATE_W = 3;
    localparam int LED_DUR_W  = 16;
    localparam int RATE_OFF   = 0;

    typedef struct packed {
        logic [LED_RATE_W-1:0] rate;
        logic [LED_DUR_W-1:0]  dur;
    } led_step_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/led_seq_table.sv
// Step table register file: one write port, one combinational read port.
// A same-cycle write is visible only after the edge, so reads return pre-write data.
module led_seq_table
    import led_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter type STEP_T = led_step_t
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  STEP_T                    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output STEP_T                    rd_data
);

    STEP_T r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/led_pattern_seq.sv
// Plays a programmable table of (rate, duration) steps onto ledmod's rate select,
// once or looped, with start/stop/busy/done sequencing.
module led_pattern_seq
    import led_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DUR_W  = 16,
    parameter int RATE_W = 3
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [RATE_W-1:0]        wr_rate,
    input  logic [DUR_W-1:0]         wr_dur,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic                     loop_en,
    input  logic                     start,
    input  logic                     stop,
    output logic [RATE_W-1:0]        rate_sel,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] step_idx
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;

    typedef struct packed {
        logic [RATE_W-1:0] rate;
        logic [DUR_W-1:0]  dur;
    } step_t;

    seq_state_e        r_state, w_state_nxt;
    logic [RATE_W-1:0] r_rate, w_rate_nxt;
    logic [DUR_W-1:0]  r_cnt, w_cnt_nxt, w_load_cnt;
    logic [IW-1:0]     r_idx, w_idx_nxt, w_idx_inc, w_rd_addr;
    logic [LW-1:0]     r_len, w_len_nxt;
    logic              r_loop, w_loop_nxt;
    logic              r_done, w_done_nxt;
    logic              w_len_ok, w_last, w_step_end;
    step_t             w_wr_step, w_rd_step;

    assign w_wr_step = '{rate: wr_rate, dur: wr_dur};

    led_seq_table #(
        .DEPTH  (DEPTH),
        .STEP_T (step_t)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (w_wr_step),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_step)
    );

    assign w_len_ok   = (len != '0) && (len <= LW'(DEPTH));
    assign w_last     = ({1'b0, r_idx} == (r_len - LW'(1)));
    assign w_step_end = (r_cnt == DUR_W'(1));
    assign w_idx_inc  = r_idx + IW'(1);
    // The read port always points at whichever entry the next step boundary would load.
    assign w_rd_addr  = ((r_state == RUN) && !w_last) ? w_idx_inc : '0;
    assign w_load_cnt = (w_rd_step.dur == '0) ? DUR_W'(1) : w_rd_step.dur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rate  <= RATE_W'(RATE_OFF);
            r_cnt   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_loop  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rate  <= w_rate_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
            r_loop  <= w_loop_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rate_nxt  = r_rate;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_loop_nxt  = r_loop;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start && !stop && w_len_ok) begin
                    w_state_nxt = RUN;
                    w_len_nxt   = len;
                    w_loop_nxt  = loop_en;
                    w_rate_nxt  = w_rd_step.rate;
                    w_cnt_nxt   = w_load_cnt;
                    w_idx_nxt   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_rate_nxt  = RATE_W'(RATE_OFF);
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (w_step_end) begin
                    if (w_last && !r_loop) begin
                        w_state_nxt = IDLE;
                        w_rate_nxt  = RATE_W'(RATE_OFF);
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_rate_nxt = w_rd_step.rate;
                        w_cnt_nxt  = w_load_cnt;
                        w_idx_nxt  = w_rd_addr;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - DUR_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rate_sel = r_rate;
    assign busy     = (r_state == RUN);
    assign done     = r_done;
    assign step_idx = r_idx;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: vector table plus hand-written corner sequences,
// with expected per-cycle outputs queued as each scenario is driven.
module tb_led_pattern_seq;

    localparam int DEPTH  = 8;
    localparam int DUR_W  = 8;
    localparam int RATE_W = 3;
    localparam int IW     = 3;
    localparam int LW     = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [IW-1:0]     wr_addr = '0;
    logic [RATE_W-1:0] wr_rate = '0;
    logic [DUR_W-1:0]  wr_dur = '0;
    logic [LW-1:0]     len = '0;
    logic              loop_en = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [RATE_W-1:0] rate_sel;
    logic              busy;
    logic              done;
    logic [IW-1:0]     step_idx;

    always #5 clk = ~clk;

    led_pattern_seq #(
        .DEPTH  (DEPTH),
        .DUR_W  (DUR_W),
        .RATE_W (RATE_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_rate  (wr_rate),
        .wr_dur   (wr_dur),
        .len      (len),
        .loop_en  (loop_en),
        .start    (start),
        .stop     (stop),
        .rate_sel (rate_sel),
        .busy     (busy),
        .done     (done),
        .step_idx (step_idx)
    );

    typedef struct packed {
        logic [RATE_W-1:0] rate;
        logic              busy;
        logic              done;
        logic [IW-1:0]     idx;
    } obs_t;

    typedef struct {
        int len;
        bit loop;
        int stopAt;
        int ncycles;
        int expBusy;
    } vec_t;

    obs_t expQ[$];
    int   tests = 0;
    int   fails = 0;
    int   mRate[DEPTH];
    int   mDur[DEPTH];
    int   busyCount;

    function automatic obs_t mkObs(int r, bit b, bit d, int i);
        obs_t o;
        o.rate = RATE_W'(r);
        o.busy = b;
        o.done = d;
        o.idx  = IW'(i);
        return o;
    endfunction

    task automatic checkOutput(input string name, input obs_t exp);
        obs_t act;
        act = mkObs(int'(rate_sel), busy, done, int'(step_idx));
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got rate=%0d busy=%0d done=%0d idx=%0d, expected rate=%0d busy=%0d done=%0d idx=%0d",
                     name, act.rate, act.busy, act.done, act.idx, exp.rate, exp.busy, exp.done, exp.idx);
        end
    endtask

    task automatic writeEntry(input int a, input int r, input int d);
        wr_en   = 1'b1;
        wr_addr = IW'(a);
        wr_rate = RATE_W'(r);
        wr_dur  = DUR_W'(d);
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        mRate[a] = r;
        mDur[a]  = d;
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) begin
            mRate[i] = 0;
            mDur[i]  = 0;
        end
    endtask

    // Expands the model table into one expected record per cycle after the start edge.
    task automatic buildTrace(input int l, input bit lp, input int ncycles, input int stopAt);
        int rates[$];
        int idxs[$];
        int total;
        if (l < 1 || l > DEPTH) begin
            for (int c = 0; c < ncycles; c++) expQ.push_back(mkObs(0, 0, 0, 0));
            return;
        end
        for (int i = 0; i < l; i++) begin
            for (int k = 0; k < ((mDur[i] == 0) ? 1 : mDur[i]); k++) begin
                rates.push_back(mRate[i]);
                idxs.push_back(i);
            end
        end
        total = rates.size();
        for (int c = 0; c < ncycles; c++) begin
            if (stopAt >= 0 && c > stopAt)  expQ.push_back(mkObs(0, 0, 0, 0));
            else if (c < total)             expQ.push_back(mkObs(rates[c], 1, 0, idxs[c]));
            else if (lp)                    expQ.push_back(mkObs(rates[c % total], 1, 0, idxs[c % total]));
            else if (c == total)            expQ.push_back(mkObs(0, 0, 1, 0));
            else                            expQ.push_back(mkObs(0, 0, 0, 0));
        end
    endtask

    // Drives one start and consumes the queued expectations one cycle at a time.
    task automatic applyStimulus(input string name, input int l, input bit lp, input int stopAt,
                                 input int startAgainAt, input int wrAt, input int wa, input int wrr, input int wd);
        int n;
        len       = LW'(l);
        loop_en   = lp;
        start     = 1'b1;
        busyCount = 0;
        n = expQ.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s c%0d", name, c), expQ.pop_front());
            if (busy) busyCount++;
            start   = (c == startAgainAt);
            stop    = (c == stopAt);
            wr_en   = (c == wrAt);
            wr_addr = IW'(wa);
            wr_rate = RATE_W'(wrr);
            wr_dur  = DUR_W'(wd);
        end
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
        if (wrAt >= 0) begin
            mRate[wa] = wrr;
            mDur[wa]  = wd;
        end
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{len: 3, loop: 1'b0, stopAt: -1, ncycles: 21, expBusy: 18};
        vecs[1] = '{len: 3, loop: 1'b1, stopAt: 24, ncycles: 28, expBusy: 25};
        vecs[2] = '{len: 1, loop: 1'b0, stopAt: -1, ncycles: 12, expBusy: 10};
        vecs[3] = '{len: 2, loop: 1'b0, stopAt: -1, ncycles: 17, expBusy: 15};
        vecs[4] = '{len: 0, loop: 1'b0, stopAt: -1, ncycles: 4,  expBusy: 0};
        vecs[5] = '{len: 9, loop: 1'b0, stopAt: -1, ncycles: 4,  expBusy: 0};
        vecs[6] = '{len: 8, loop: 1'b0, stopAt: -1, ncycles: 25, expBusy: 23};
        vecs[7] = '{len: 3, loop: 1'b1, stopAt: 0,  ncycles: 3,  expBusy: 1};
        vecs[8] = '{len: 3, loop: 1'b0, stopAt: -1, ncycles: 16, expBusy: 14};
        clearModel();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("in reset", mkObs(0, 0, 0, 0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after reset", mkObs(0, 0, 0, 0));

        writeEntry(0, 1, 10);
        writeEntry(1, 4, 5);
        writeEntry(2, 7, 3);

        for (int i = 0; i < 9; i++) begin
            if (i == 8) writeEntry(1, 4, 0);
            buildTrace(vecs[i].len, vecs[i].loop, vecs[i].ncycles, vecs[i].stopAt);
            applyStimulus($sformatf("vec%0d", i), vecs[i].len, vecs[i].loop, vecs[i].stopAt, -1, -1, 0, 0, 0);
            tests++;
            if (busyCount != vecs[i].expBusy) begin
                fails++;
                $display("[TB] FAIL vec%0d busy cycles: got %0d, expected %0d", i, busyCount, vecs[i].expBusy);
            end
        end

        // Rewriting the next entry while entry 0 plays takes effect when it loads.
        writeEntry(0, 3, 3);
        writeEntry(1, 5, 2);
        for (int c = 0; c < 3; c++) expQ.push_back(mkObs(3, 1, 0, 0));
        for (int c = 0; c < 4; c++) expQ.push_back(mkObs(2, 1, 0, 1));
        expQ.push_back(mkObs(0, 0, 1, 0));
        expQ.push_back(mkObs(0, 0, 0, 0));
        applyStimulus("rewrite next", 2, 1'b0, -1, -1, 0, 1, 2, 4);

        // Rewriting the active entry and re-pulsing start must not disturb playback.
        for (int c = 0; c < 3; c++) expQ.push_back(mkObs(3, 1, 0, 0));
        for (int c = 0; c < 4; c++) expQ.push_back(mkObs(2, 1, 0, 1));
        expQ.push_back(mkObs(0, 0, 1, 0));
        expQ.push_back(mkObs(0, 0, 0, 0));
        applyStimulus("rewrite active", 2, 1'b0, -1, 1, 0, 0, 6, 9);

        len   = LW'(3);
        start = 1'b1;
        stop  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("start+stop idle c%0d", c), mkObs(0, 0, 0, 0));
        end
        start = 1'b0;
        stop  = 1'b0;

        // Asynchronous reset mid-run clears outputs before the next edge and empties the table.
        len     = LW'(2);
        loop_en = 1'b1;
        start   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("running before reset", mkObs(6, 1, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset", mkObs(0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearModel();
        buildTrace(1, 1'b0, 3, -1);
        applyStimulus("cleared table", 1, 1'b0, -1, -1, -1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
